// File: rtl/uart_pkg.sv
// Definitions shared by the 8N1 UART: the FSM state set used by both
// directions, and the frame and oversampling sizes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_if.sv
// Byte-side handshake of the UART: the transmit strobe and busy flag, and the
// sticky receive-ready flag with its clear input.
interface uart_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] din;
    logic                 wr_en;
    logic                 tx_busy;
    logic                 rdy;
    logic                 rdy_clr;
    logic [DATA_BITS-1:0] dout;

    modport master (
        output din, wr_en, rdy_clr,
        input  tx_busy, rdy, dout
    );

    modport slave (
        input  din, wr_en, rdy_clr,
        output tx_busy, rdy, dout
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running dividers producing a one-cycle tick per transmit bit period
// and per receive oversample period.
module uart_baud_gen import uart_pkg::*; #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic tx_tick,
    output logic rx_tick
);

    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (OVERSAMPLE * BAUD);
    // TX_DIV is always the larger divisor, so one width covers both counters.
    localparam int CNT_W  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    logic [1:0] ticks;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div
            localparam int DIV = (gi == 0) ? TX_DIV : RX_DIV;

            logic [CNT_W-1:0] cnt_reg;
            logic             tick_reg;

            always_ff @(posedge clk_50m or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                end else if (cnt_reg == CNT_W'(DIV - 1)) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                end else begin
                    cnt_reg  <= cnt_reg + 1'b1;
                    tick_reg <= 1'b0;
                end
            end

            assign ticks[gi] = tick_reg;
        end
    endgenerate

    assign tx_tick = ticks[0];
    assign rx_tick = ticks[1];

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: transmitter clocked by the bit-rate tick, receiver
// clocked by the 16x oversample tick, sharing one baud generator.
module uart_core import uart_pkg::*; #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic   clk_50m,
    input  logic   rst_n,
    uart_if.slave  bus,
    output logic   tx,
    input  logic   rx
);

    logic tx_tick;
    logic rx_tick;

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_gen (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .tx_tick (tx_tick),
        .rx_tick (rx_tick)
    );

    uart_state_e          tx_state_reg;
    logic [DATA_BITS-1:0] tx_data_reg;
    logic [IDX_W-1:0]     tx_idx_reg;
    logic                 tx_reg;
    logic                 tx_busy_reg;

    // In STOP, tx_idx_reg marks whether the stop level has been driven yet,
    // so the stop bit lasts one full tick period before IDLE.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= IDLE;
            tx_data_reg  <= '0;
            tx_idx_reg   <= '0;
            tx_reg       <= 1'b1;
            tx_busy_reg  <= 1'b0;
        end else begin
            case (tx_state_reg)
                IDLE: begin
                    if (bus.wr_en) begin
                        tx_data_reg  <= bus.din;
                        tx_idx_reg   <= '0;
                        tx_busy_reg  <= 1'b1;
                        tx_state_reg <= START;
                    end
                end
                START: begin
                    if (tx_tick) begin
                        tx_reg       <= 1'b0;
                        tx_state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (tx_tick) begin
                        tx_reg <= tx_data_reg[tx_idx_reg];
                        if (tx_idx_reg == IDX_W'(DATA_BITS - 1)) begin
                            tx_idx_reg   <= '0;
                            tx_state_reg <= STOP;
                        end else begin
                            tx_idx_reg <= tx_idx_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tx_tick) begin
                        if (tx_idx_reg == '0) begin
                            tx_reg     <= 1'b1;
                            tx_idx_reg <= IDX_W'(1);
                        end else begin
                            tx_idx_reg   <= '0;
                            tx_busy_reg  <= 1'b0;
                            tx_state_reg <= IDLE;
                        end
                    end
                end
                default: tx_state_reg <= IDLE;
            endcase
        end
    end

    logic [1:0]           rx_sync_reg;
    logic                 rx_s;
    uart_state_e          rx_state_reg;
    logic [SAMPLE_W-1:0]  rx_cnt_reg;
    logic [IDX_W-1:0]     rx_idx_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic [DATA_BITS-1:0] dout_reg;
    logic                 rdy_reg;

    assign rx_s = rx_sync_reg[1];

    // The synchroniser resets to the idle level so reset release never looks
    // like a start bit. A completing byte sets rdy after the clear, so set wins.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_reg  <= 2'b11;
            rx_state_reg <= IDLE;
            rx_cnt_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
            dout_reg     <= '0;
            rdy_reg      <= 1'b0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], rx};
            if (bus.rdy_clr) begin
                rdy_reg <= 1'b0;
            end
            if (rx_tick) begin
                case (rx_state_reg)
                    IDLE: begin
                        if (!rx_s) begin
                            rx_cnt_reg   <= SAMPLE_W'(1);
                            rx_state_reg <= START;
                        end
                    end
                    START: begin
                        // Counter holds the samples taken so far; this is sample 8.
                        if (rx_cnt_reg == SAMPLE_W'(OVERSAMPLE / 2 - 1)) begin
                            if (!rx_s) begin
                                rx_cnt_reg   <= '0;
                                rx_idx_reg   <= '0;
                                rx_state_reg <= DATA;
                            end else begin
                                rx_state_reg <= IDLE;
                            end
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    DATA: begin
                        if (rx_cnt_reg == SAMPLE_W'(OVERSAMPLE - 1)) begin
                            rx_shift_reg[rx_idx_reg] <= rx_s;
                            rx_cnt_reg               <= '0;
                            if (rx_idx_reg == IDX_W'(DATA_BITS - 1)) begin
                                rx_state_reg <= STOP;
                            end else begin
                                rx_idx_reg <= rx_idx_reg + 1'b1;
                            end
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    STOP: begin
                        if (rx_cnt_reg == SAMPLE_W'(OVERSAMPLE - 1)) begin
                            if (rx_s) begin
                                dout_reg <= rx_shift_reg;
                                rdy_reg  <= 1'b1;
                            end
                            rx_cnt_reg   <= '0;
                            rx_state_reg <= IDLE;
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    default: rx_state_reg <= IDLE;
                endcase
            end
        end
    end

    assign tx          = tx_reg;
    assign bus.tx_busy = tx_busy_reg;
    assign bus.rdy     = rdy_reg;
    assign bus.dout    = dout_reg;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at 16 clocks per bit: stimulus pushes expected bytes to
// a queue, a monitor pops and compares each time rdy is raised.
module tb_uart_core;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 3125000;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic tx;
    logic rx;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b1;

    uart_if bus();

    assign rx = loop_en ? tx : rx_drv;

    uart_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus),
        .tx      (tx),
        .rx      (rx)
    );

    always #10 clk_50m = ~clk_50m;

    int         checks    = 0;
    int         failures  = 0;
    int         rdy_rises = 0;
    logic [7:0] last_rx   = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Line level of 8N1 frame position i: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return 1'(((32'(b)) >> (i - 1)) % 2);
    endfunction

    // Scoreboard monitor: every rdy seen is matched against the oldest write.
    initial begin
        logic [7:0] e;
        bus.rdy_clr = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (bus.rdy_clr) begin
                bus.rdy_clr = 1'b0;
            end else if (bus.rdy === 1'b1) begin
                rdy_rises++;
                check("rdy_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_dout", 32'(bus.dout), 32'(e));
                    last_rx = e;
                    $display("rx byte got=%02h want=%02h", bus.dout, e);
                end
                bus.rdy_clr = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        if (n >= budget) check("tx_idle_timeout", 32'(bus.tx_busy), 32'd0);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_rx);
        wait_idle(400);
        bus.din   = b;
        bus.wr_en = 1'b1;
        if (expect_rx) exp_q.push_back(b);
        @(negedge clk_50m);
        bus.wr_en = 1'b0;
        $display("tx write %02h", b);
    endtask

    task automatic wait_tx_fall(input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        if (n >= budget) check("tx_start_timeout", 32'(tx), 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_level, input int stop_len);
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop_level : frame_bit(b, i);
            repeat ((i == 9) ? stop_len : BIT_CYC) @(negedge clk_50m);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r;
        logic [7:0] rb;
        bus.din   = 8'h00;
        bus.wr_en = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_busy", 32'(bus.tx_busy), 32'd0);
        check("reset_rdy", 32'(bus.rdy), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'h00);
        rst_n = 1'b1;
        repeat (200) @(negedge clk_50m);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_rdy", 32'(bus.rdy), 32'd0);

        // Single frame waveform, sampled mid-bit
        write_byte(8'hA5, 1'b1);
        wait_tx_fall(40);
        repeat (BIT_CYC / 2) @(negedge clk_50m);
        for (int i = 0; i < 10; i++) begin
            check("a5_line_bit", 32'(tx), 32'(frame_bit(8'hA5, i)));
            check("a5_busy_high", 32'(bus.tx_busy), 32'd1);
            if (i < 9) repeat (BIT_CYC) @(negedge clk_50m);
        end
        repeat (10) @(negedge clk_50m);
        check("a5_busy_low_after_stop", 32'(bus.tx_busy), 32'd0);
        drain(400);

        // Exhaustive loopback
        for (int v = 0; v < 256; v++) begin
            write_byte(v[7:0], 1'b1);
        end
        drain(1000);

        // Randomised bytes with random idle gaps
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk_50m);
            rb = 8'($urandom_range(0, 255));
            write_byte(rb, 1'b1);
        end
        drain(1000);

        // Write while busy is dropped
        r = rdy_rises;
        write_byte(8'h3C, 1'b1);
        repeat (50) @(negedge clk_50m);
        check("busy_mid_frame", 32'(bus.tx_busy), 32'd1);
        bus.din   = 8'hC3;
        bus.wr_en = 1'b1;
        @(negedge clk_50m);
        bus.wr_en = 1'b0;
        drain(600);
        repeat (300) @(negedge clk_50m);
        check("busy_drop_rdy_count", 32'(rdy_rises - r), 32'd1);
        check("busy_drop_last_byte", 32'(last_rx), 32'h3C);

        // Framing error; stop released early so the trailing low is seen as a glitch
        loop_en = 1'b0;
        repeat (20) @(negedge clk_50m);
        r = rdy_rises;
        drive_frame(8'h55, 1'b0, 12);
        repeat (100) @(negedge clk_50m);
        check("frame_err_rdy", 32'(bus.rdy), 32'd0);
        check("frame_err_dout", 32'(bus.dout), 32'(last_rx));
        check("frame_err_rdy_count", 32'(rdy_rises - r), 32'd0);
        exp_q.push_back(8'h12);
        drive_frame(8'h12, 1'b1, BIT_CYC);
        drain(200);
        check("frame_ok_rdy_count", 32'(rdy_rises - r), 32'd1);
        loop_en = 1'b1;
        repeat (20) @(negedge clk_50m);

        // Reset during data bit 4 of a transmit
        write_byte(8'h0F, 1'b0);
        wait_tx_fall(40);
        repeat (BIT_CYC / 2 + 5 * BIT_CYC) @(negedge clk_50m);
        check("mid_bit4_level", 32'(tx), 32'(frame_bit(8'h0F, 5)));
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx", 32'(tx), 32'd1);
        check("mid_reset_tx_busy", 32'(bus.tx_busy), 32'd0);
        check("mid_reset_rdy", 32'(bus.rdy), 32'd0);
        repeat (3) @(negedge clk_50m);
        rst_n   = 1'b1;
        last_rx = 8'h00;
        check("mid_reset_dout", 32'(bus.dout), 32'h00);
        repeat (20) @(negedge clk_50m);
        r = rdy_rises;
        write_byte(8'h81, 1'b1);
        drain(600);
        repeat (50) @(negedge clk_50m);
        check("post_reset_rdy_count", 32'(rdy_rises - r), 32'd1);
        check("post_reset_last_byte", 32'(last_rx), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
